// File: rtl/pc_stack_unit.sv
// Program-counter unit: PC register, next-PC source mux and a hardware
// return-address stack for CALL/RET and interrupt entry/return.
module pc_stack_unit #(
    parameter int              PC_W      = 10,
    parameter int              IR_W      = 18,
    parameter int              IR_LSB    = 3,
    parameter int              STK_DEPTH = 8,
    parameter logic [PC_W-1:0] INTR_VEC  = '1,
    parameter logic [PC_W-1:0] RST_VEC   = '0,
    localparam int             CNT_W     = $clog2(STK_DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IR_W-1:0]  i_ir,
    input  logic [1:0]       i_pc_mux_sel,
    input  logic             i_pc_ld,
    input  logic             i_pc_inc,
    input  logic             i_call,
    input  logic             i_ret,
    input  logic             i_stk_clr,
    output logic [PC_W-1:0]  o_pc_count,
    output logic [PC_W-1:0]  o_din_mux,
    output logic [CNT_W-1:0] o_stk_depth,
    output logic             o_stk_full,
    output logic             o_stk_empty,
    output logic             o_stk_err
);

    localparam int IDX_W = $clog2(STK_DEPTH);

    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic [PC_W-1:0]  r_stk [STK_DEPTH];

    logic [PC_W-1:0]  w_pc_plus1;
    logic [PC_W-1:0]  w_top;
    logic [PC_W-1:0]  w_push_val;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_conflict;

    assign w_pc_plus1 = r_pc + PC_W'(1);
    assign w_full     = (r_cnt == CNT_W'(STK_DEPTH));
    assign w_empty    = (r_cnt == '0);
    assign w_push     = i_call & ~i_ret;
    assign w_pop      = i_ret & ~i_call;
    assign w_conflict = i_call & i_ret;

    // Indices are only used when in range (write when not full, read when not empty).
    assign w_wr_idx   = IDX_W'(r_cnt);
    assign w_rd_idx   = IDX_W'(r_cnt - CNT_W'(1));
    assign w_top      = w_empty ? RST_VEC : r_stk[w_rd_idx];

    // An interrupt pushes the current PC so the interrupted instruction re-executes.
    assign w_push_val = (i_pc_mux_sel == 2'b10) ? r_pc : w_pc_plus1;

    always_comb begin
        o_din_mux = RST_VEC;
        case (i_pc_mux_sel)
            2'b00:   o_din_mux = i_ir[IR_LSB +: PC_W];
            2'b01:   o_din_mux = w_top;
            2'b10:   o_din_mux = INTR_VEC;
            default: o_din_mux = RST_VEC;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RST_VEC;
        end else if (i_pc_ld) begin
            r_pc <= o_din_mux;
        end else if (i_pc_inc) begin
            r_pc <= w_pc_plus1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (i_stk_clr) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_conflict) begin
            r_err <= 1'b1;
        end else if (w_push) begin
            if (w_full) r_err <= 1'b1;
            else        r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_pop) begin
            if (w_empty) r_err <= 1'b1;
            else         r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Stack storage carries no reset; entries above the count are never observed.
    always_ff @(posedge i_clk) begin
        if (!i_stk_clr && w_push && !w_full) begin
            r_stk[w_wr_idx] <= w_push_val;
        end
    end

    assign o_pc_count  = r_pc;
    assign o_stk_depth = r_cnt;
    assign o_stk_full  = w_full;
    assign o_stk_empty = w_empty;
    assign o_stk_err   = r_err;

endmodule
